// File: rtl/core_decode_pkg.sv
// Shared decode types for core_decode_queue: opcodes, op classes, function codes and the packed micro-op.
package core_decode_pkg;

    localparam logic [6:0] OPC_IO       = 7'b0000001;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_ROT      = 7'b0001011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;

    typedef enum logic [3:0] {
        OC_ALU, OC_ALUI, OC_BRANCH, OC_LOAD, OC_STORE, OC_JAL, OC_JALR, OC_LUI,
        OC_AUIPC, OC_FPU, OC_FLOAD, OC_FSTORE, OC_IO, OC_ROT, OC_ILLEGAL
    } op_class_e;

    typedef enum logic [4:0] {
        F_ADD, F_SUB, F_SLL, F_SLT, F_SLTU, F_XOR, F_SRL, F_SRA, F_OR, F_AND,
        F_BEQ, F_BNE, F_BLT, F_BGE, F_BLTU, F_BGEU,
        F_LB, F_LH, F_LW, F_LBU, F_LHU, F_SB, F_SH, F_SW,
        F_IN, F_OUT
    } func_e;

    // FP codes share encodings with integer ones; op_class FPU tells them apart.
    localparam func_e F_FADD   = F_ADD;
    localparam func_e F_FSUB   = F_SUB;
    localparam func_e F_FMUL   = F_SLL;
    localparam func_e F_FDIV   = F_SLT;
    localparam func_e F_FSQRT  = F_SLTU;
    localparam func_e F_FSGNJX = F_XOR;
    localparam func_e F_FEQ    = F_SRL;
    localparam func_e F_FLT    = F_SRA;
    localparam func_e F_FLE    = F_OR;
    localparam func_e F_FCVTWS = F_AND;
    localparam func_e F_FCVTSW = F_BEQ;
    localparam func_e F_FMVWX  = F_BNE;

    typedef enum logic [2:0] {FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_e;

    typedef struct packed {
        op_class_e  op_class;
        func_e      func;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rd_fp;
        logic       rs1_fp;
        logic       rs2_fp;
    } uop_t;

    localparam int UOP_W = $bits(uop_t);

    function automatic func_e alu_func(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? F_SUB : F_ADD;
            3'b001:  return F_SLL;
            3'b010:  return F_SLT;
            3'b011:  return F_SLTU;
            3'b100:  return F_XOR;
            3'b101:  return alt ? F_SRA : F_SRL;
            3'b110:  return F_OR;
            default: return F_AND;
        endcase
    endfunction

endpackage

// File: rtl/core_decode_logic.sv
// Combinational instruction decoder: INST -> {uop_t, IMM, ILLEGAL}.
// FP classes are decoded only when CORE_DECODE_FPU_EN is defined.
module core_decode_logic
    import core_decode_pkg::*;
(
    input  logic [31:0] INST,
    output uop_t        UOP,
    output logic [31:0] IMM,
    output logic        ILLEGAL
);

    logic [6:0] opcode;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] rd_f, rs1_f, rs2_f;
    logic       rm_ok;

    assign opcode = INST[6:0];
    assign rd_f   = INST[11:7];
    assign f3     = INST[14:12];
    assign rs1_f  = INST[19:15];
    assign rs2_f  = INST[24:20];
    assign f7     = INST[31:25];
    assign rm_ok  = (f3 != 3'b101) && (f3 != 3'b110);

    op_class_e cls;
    func_e     fn;
    imm_fmt_e  fmt;
    logic      ok, use_rd, use_rs1, use_rs2, fp_rd, fp_rs1, fp_rs2;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cls = OC_ILLEGAL;  fn = F_ADD;  fmt = FMT_NONE;  ok = 1'b0;
        use_rd = 1'b0;  use_rs1 = 1'b0;  use_rs2 = 1'b0;
        fp_rd  = 1'b0;  fp_rs1  = 1'b0;  fp_rs2  = 1'b0;
        case (opcode)
            OPC_LUI:   begin cls = OC_LUI;   ok = 1'b1; use_rd = 1'b1; fmt = FMT_U; end
            OPC_AUIPC: begin cls = OC_AUIPC; ok = 1'b1; use_rd = 1'b1; fmt = FMT_U; end
            OPC_JAL:   begin cls = OC_JAL;   ok = 1'b1; use_rd = 1'b1; fmt = FMT_J; end
            OPC_JALR:  begin
                cls = OC_JALR; ok = (f3 == 3'b000); use_rd = 1'b1; use_rs1 = 1'b1; fmt = FMT_I;
            end
            OPC_BRANCH: begin
                cls = OC_BRANCH; ok = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; fmt = FMT_B;
                case (f3)
                    3'b000:  fn = F_BEQ;
                    3'b001:  fn = F_BNE;
                    3'b100:  fn = F_BLT;
                    3'b101:  fn = F_BGE;
                    3'b110:  fn = F_BLTU;
                    3'b111:  fn = F_BGEU;
                    default: ok = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                cls = OC_LOAD; ok = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; fmt = FMT_I;
                case (f3)
                    3'b000:  fn = F_LB;
                    3'b001:  fn = F_LH;
                    3'b010:  fn = F_LW;
                    3'b100:  fn = F_LBU;
                    3'b101:  fn = F_LHU;
                    default: ok = 1'b0;
                endcase
            end
            OPC_STORE: begin
                cls = OC_STORE; ok = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; fmt = FMT_S;
                case (f3)
                    3'b000:  fn = F_SB;
                    3'b001:  fn = F_SH;
                    3'b010:  fn = F_SW;
                    default: ok = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                cls = OC_ALUI; use_rd = 1'b1; use_rs1 = 1'b1; fmt = FMT_I;
                fn  = alu_func(f3, (f3 == 3'b101) && INST[30]);
                case (f3)
                    3'b001:  ok = (f7 == 7'b0000000);
                    3'b101:  ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    default: ok = 1'b1;
                endcase
            end
            OPC_OP: begin
                cls = OC_ALU; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                fn  = alu_func(f3, INST[30]);
                ok  = (f7 == 7'b0000000) ||
                      ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
            end
            OPC_IO: begin
                cls = OC_IO;
                case (f3)
                    3'b000:  begin ok = 1'b1; fn = F_IN;  use_rd  = 1'b1; end
                    3'b001:  begin ok = 1'b1; fn = F_OUT; use_rs1 = 1'b1; end
                    default: ok = 1'b0;
                endcase
            end
            OPC_ROT: begin
                // Custom rotate: R-type, f3 001 rotates left, 101 rotates right.
                cls = OC_ROT; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                fn  = (f3 == 3'b001) ? F_SLL : F_SRL;
                ok  = (f7 == 7'b0000000) && ((f3 == 3'b001) || (f3 == 3'b101));
            end
`ifdef CORE_DECODE_FPU_EN
            OPC_LOAD_FP: begin
                cls = OC_FLOAD; fn = F_LW; ok = (f3 == 3'b010); fmt = FMT_I;
                use_rd = 1'b1; fp_rd = 1'b1; use_rs1 = 1'b1;
            end
            OPC_STORE_FP: begin
                cls = OC_FSTORE; fn = F_SW; ok = (f3 == 3'b010); fmt = FMT_S;
                use_rs1 = 1'b1; use_rs2 = 1'b1; fp_rs2 = 1'b1;
            end
            OPC_OP_FP: begin
                cls = OC_FPU; use_rd = 1'b1; use_rs1 = 1'b1;
                case (f7)
                    7'b0000000: begin fn = F_FADD; ok = rm_ok; use_rs2 = 1'b1; {fp_rd, fp_rs1, fp_rs2} = 3'b111; end
                    7'b0000100: begin fn = F_FSUB; ok = rm_ok; use_rs2 = 1'b1; {fp_rd, fp_rs1, fp_rs2} = 3'b111; end
                    7'b0001000: begin fn = F_FMUL; ok = rm_ok; use_rs2 = 1'b1; {fp_rd, fp_rs1, fp_rs2} = 3'b111; end
                    7'b0001100: begin fn = F_FDIV; ok = rm_ok; use_rs2 = 1'b1; {fp_rd, fp_rs1, fp_rs2} = 3'b111; end
                    7'b0101100: begin fn = F_FSQRT; ok = rm_ok && (rs2_f == 5'd0); {fp_rd, fp_rs1} = 2'b11; end
                    7'b0010000: begin fn = F_FSGNJX; ok = (f3 == 3'b010); use_rs2 = 1'b1; {fp_rd, fp_rs1, fp_rs2} = 3'b111; end
                    7'b1010000: begin
                        use_rs2 = 1'b1; {fp_rs1, fp_rs2} = 2'b11; ok = 1'b1;
                        case (f3)
                            3'b010:  fn = F_FEQ;
                            3'b001:  fn = F_FLT;
                            3'b000:  fn = F_FLE;
                            default: ok = 1'b0;
                        endcase
                    end
                    7'b1100000: begin fn = F_FCVTWS; ok = rm_ok && (rs2_f == 5'd0); fp_rs1 = 1'b1; end
                    7'b1101000: begin fn = F_FCVTSW; ok = rm_ok && (rs2_f == 5'd0); fp_rd  = 1'b1; end
                    7'b1111000: begin fn = F_FMVWX; ok = (f3 == 3'b000) && (rs2_f == 5'd0); fp_rd = 1'b1; end
                    default:    ok = 1'b0;
                endcase
            end
`endif
            default: ok = 1'b0;
        endcase
    end

    always_comb begin
        UOP          = '0;
        UOP.op_class = OC_ILLEGAL;
        IMM          = '0;
        ILLEGAL      = !ok;
        if (ok) begin
            UOP.op_class = cls;
            UOP.func     = fn;
            UOP.rd       = use_rd  ? rd_f  : 5'd0;
            UOP.rs1      = use_rs1 ? rs1_f : 5'd0;
            UOP.rs2      = use_rs2 ? rs2_f : 5'd0;
            UOP.rd_fp    = use_rd  && fp_rd;
            UOP.rs1_fp   = use_rs1 && fp_rs1;
            UOP.rs2_fp   = use_rs2 && fp_rs2;
            case (fmt)
                FMT_I:   IMM = {{20{INST[31]}}, INST[31:20]};
                FMT_S:   IMM = {{20{INST[31]}}, INST[31:25], INST[11:7]};
                FMT_B:   IMM = {{19{INST[31]}}, INST[31], INST[7], INST[30:25], INST[11:8], 1'b0};
                FMT_U:   IMM = {INST[31:12], 12'b0};
                FMT_J:   IMM = {{11{INST[31]}}, INST[31], INST[19:12], INST[20], INST[30:21], 1'b0};
                default: IMM = '0;
            endcase
        end
    end

endmodule

// File: rtl/core_decode_queue.sv
// Decode stage with a DEPTH-entry FIFO of decoded micro-ops between fetch and issue.
// Optional FP decode: CORE_DECODE_FPU_EN.
module core_decode_queue
    import core_decode_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   FLUSH,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [31:0]            IN_INST,
    input  logic [ADDR_W-1:0]      IN_PC,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [ADDR_W-1:0]      OUT_PC,
    output logic [UOP_W-1:0]       OUT_UOP,
    output logic [31:0]            OUT_IMM,
    output logic                   OUT_ILLEGAL,
    output logic [$clog2(DEPTH):0] COUNT
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        uop_t              uop;
        logic [31:0]       imm;
        logic              illegal;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             ready_en, push, pop;
    uop_t             dec_uop;
    logic [31:0]      dec_imm;
    logic             dec_illegal;

    core_decode_logic u_decode (
        .INST    (IN_INST),
        .UOP     (dec_uop),
        .IMM     (dec_imm),
        .ILLEGAL (dec_illegal)
    );

    assign OUT_VALID = (count != '0);
    assign IN_READY  = ready_en && (count != FULL_COUNT) && !FLUSH;
    assign push      = IN_VALID && IN_READY;
    assign pop       = OUT_VALID && OUT_READY;
    assign COUNT     = count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (FLUSH) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the entry storage is not reset; count gates every read, so stale contents never escape.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr].pc      <= IN_PC;
            mem[wr_ptr].uop     <= dec_uop;
            mem[wr_ptr].imm     <= dec_imm;
            mem[wr_ptr].illegal <= dec_illegal;
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        OUT_PC      = '0;
        OUT_UOP     = '0;
        OUT_IMM     = '0;
        OUT_ILLEGAL = 1'b0;
        if (OUT_VALID) begin
            OUT_PC      = head.pc;
            OUT_UOP     = head.uop;
            OUT_IMM     = head.imm;
            OUT_ILLEGAL = head.illegal;
        end
    end

endmodule

// File: tb/tb_core_decode_queue.sv
// Directed self-checking bench for core_decode_queue; FP expectations follow CORE_DECODE_FPU_EN.
module tb_core_decode_queue;
    import core_decode_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;

    logic                   CLK = 1'b0;
    logic                   RST, FLUSH, IN_VALID, OUT_READY;
    logic                   IN_READY, OUT_VALID, OUT_ILLEGAL;
    logic [31:0]            IN_INST, OUT_IMM;
    logic [ADDR_W-1:0]      IN_PC, OUT_PC;
    logic [UOP_W-1:0]       OUT_UOP;
    logic [$clog2(DEPTH):0] COUNT;

    core_decode_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_INST(IN_INST), .IN_PC(IN_PC),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_PC(OUT_PC),
        .OUT_UOP(OUT_UOP), .OUT_IMM(OUT_IMM), .OUT_ILLEGAL(OUT_ILLEGAL), .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic uop_t mk(input op_class_e c, input func_e f, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] fp);
        uop_t u;
        u.op_class = c;
        u.func     = f;
        u.rd       = rd;
        u.rs1      = rs1;
        u.rs2      = rs2;
        {u.rd_fp, u.rs1_fp, u.rs2_fp} = fp;
        return u;
    endfunction

    // Push one instruction into an empty queue, check the head, then pop it.
    task automatic run_vec(input string tag, input logic [31:0] inst, input uop_t exp_uop,
                           input logic [31:0] exp_imm, input logic exp_ill);
        IN_VALID = 1'b1; IN_INST = inst; IN_PC = 32'h0000_0A00; OUT_READY = 1'b1;
        tick();
        IN_VALID = 1'b0;
        #1;
        check({tag, ".valid"},   OUT_VALID,   1'b1);
        check({tag, ".uop"},     OUT_UOP,     exp_uop);
        check({tag, ".imm"},     OUT_IMM,     exp_imm);
        check({tag, ".illegal"}, OUT_ILLEGAL, exp_ill);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        uop_t ill_uop;
        ill_uop = mk(OC_ILLEGAL, F_ADD, 5'd0, 5'd0, 5'd0, 3'b000);

        RST = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b1; OUT_READY = 1'b0;
        IN_INST = 32'h0000_0013; IN_PC = '0;
        tick();
        check("rst.count", COUNT, 0);
        check("rst.out_valid", OUT_VALID, 0);
        check("rst.in_ready", IN_READY, 0);
        check("rst.out_pc", OUT_PC, 0);
        IN_VALID = 1'b0;
        tick();
        RST = 1'b0;
        #1 check("rel.in_ready_pre_edge", IN_READY, 0);
        tick();
        check("rel.in_ready", IN_READY, 1);

        // addi x1,x2,-1 right after reset, one-cycle latency
        IN_VALID = 1'b1; IN_INST = 32'hFFF1_0093; IN_PC = 32'h0000_0100; OUT_READY = 1'b1;
        #1 check("t1.out_valid_before", OUT_VALID, 0);
        tick();
        IN_VALID = 1'b0;
        #1;
        check("t1.out_valid", OUT_VALID, 1);
        check("t1.uop", OUT_UOP, mk(OC_ALUI, F_ADD, 5'd1, 5'd2, 5'd0, 3'b000));
        check("t1.imm", OUT_IMM, 32'hFFFF_FFFF);
        check("t1.pc", OUT_PC, 32'h0000_0100);
        check("t1.illegal", OUT_ILLEGAL, 0);
        tick();
        check("t1.drained", COUNT, 0);

        run_vec("add",  32'h0020_8033, mk(OC_ALU, F_ADD, 5'd0, 5'd1, 5'd2, 3'b000), 32'h0, 1'b0);
        run_vec("sub",  32'h4052_01B3, mk(OC_ALU, F_SUB, 5'd3, 5'd4, 5'd5, 3'b000), 32'h0, 1'b0);
        run_vec("sw",   32'h0051_2423, mk(OC_STORE, F_SW, 5'd0, 5'd2, 5'd5, 3'b000), 32'h8, 1'b0);
        run_vec("lw",   32'hFF83_A303, mk(OC_LOAD, F_LW, 5'd6, 5'd7, 5'd0, 3'b000), 32'hFFFF_FFF8, 1'b0);
        run_vec("beq",  32'hFE20_8EE3, mk(OC_BRANCH, F_BEQ, 5'd0, 5'd1, 5'd2, 3'b000), 32'hFFFF_FFFC, 1'b0);
        run_vec("lui",  32'h1234_52B7, mk(OC_LUI, F_ADD, 5'd5, 5'd0, 5'd0, 3'b000), 32'h1234_5000, 1'b0);
        run_vec("jal",  32'h0010_00EF, mk(OC_JAL, F_ADD, 5'd1, 5'd0, 5'd0, 3'b000), 32'h0000_0800, 1'b0);
        run_vec("out",  32'h0003_9001, mk(OC_IO, F_OUT, 5'd0, 5'd7, 5'd0, 3'b000), 32'h0, 1'b0);
        run_vec("ones", 32'hFFFF_FFFF, ill_uop, 32'h0, 1'b1);
        run_vec("badf7", 32'h4020_9033, ill_uop, 32'h0, 1'b1);
`ifdef CORE_DECODE_FPU_EN
        run_vec("fadd", 32'h0031_00D3, mk(OC_FPU, F_FADD, 5'd1, 5'd2, 5'd3, 3'b111), 32'h0, 1'b0);
`else
        run_vec("fadd", 32'h0031_00D3, ill_uop, 32'h0, 1'b1);
`endif

        // Fill to DEPTH with downstream stalled; fifth PC waits for a free slot
        OUT_READY = 1'b0; IN_VALID = 1'b1; IN_INST = 32'h0000_0013;
        for (int i = 0; i < 4; i++) begin
            IN_PC = 32'h2000 + 32'(i * 4);
            #1 check("t2.ready_fill", IN_READY, 1);
            tick();
        end
        check("t2.count_full", COUNT, 4);
        check("t2.ready_full", IN_READY, 0);
        IN_PC = 32'h2010;
        tick();
        check("t2.count_held", COUNT, 4);
        check("t2.head0", OUT_PC, 32'h2000);
        OUT_READY = 1'b1;
        #1 check("t2.no_passthrough", IN_READY, 0);
        tick();
        check("t2.count3", COUNT, 3);
        check("t2.head1", OUT_PC, 32'h2004);
        check("t2.ready_again", IN_READY, 1);
        tick();
        IN_VALID = 1'b0;
        #1;
        check("t2.count_pushpop", COUNT, 3);
        check("t2.head2", OUT_PC, 32'h2008);
        tick();
        check("t2.head3", OUT_PC, 32'h200C);
        tick();
        check("t2.head4", OUT_PC, 32'h2010);
        tick();
        check("t2.empty", OUT_VALID, 0);

        // Hold COUNT=2 with concurrent push/pop across pointer wrap
        OUT_READY = 1'b0; IN_VALID = 1'b1;
        IN_PC = 32'h3000; tick();
        IN_PC = 32'h3004; tick();
        OUT_READY = 1'b1;
        for (int i = 0; i < 10; i++) begin
            IN_PC = 32'h3000 + 32'((i + 2) * 4);
            #1 check("t3.head", OUT_PC, 32'h3000 + 32'(i * 4));
            tick();
            check("t3.count", COUNT, 2);
        end

        // Flush at COUNT=3 with a concurrent push
        OUT_READY = 1'b0; IN_PC = 32'h3030;
        tick();
        check("t4.count3", COUNT, 3);
        FLUSH = 1'b1; IN_PC = 32'hDEAD_0000; OUT_READY = 1'b1;
        #1 check("t4.ready_flush", IN_READY, 0);
        tick();
        FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        #1;
        check("t4.count", COUNT, 0);
        check("t4.out_valid", OUT_VALID, 0);
        check("t4.out_pc_zero", OUT_PC, 0);
        check("t4.out_uop_zero", OUT_UOP, 0);
        IN_VALID = 1'b1; IN_PC = 32'h4000;
        tick();
        IN_VALID = 1'b0;
        #1;
        check("t4.next_head", OUT_PC, 32'h4000);
        check("t4.next_count", COUNT, 1);
        OUT_READY = 1'b1;
        tick();
        check("t4.drained", COUNT, 0);

        // Asynchronous reset mid-stream with COUNT=3
        OUT_READY = 1'b0; IN_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            IN_PC = 32'h5000 + 32'(i * 4);
            tick();
        end
        IN_VALID = 1'b0;
        check("t6.count3", COUNT, 3);
        #2 RST = 1'b1;
        #1;
        check("t6.out_valid", OUT_VALID, 0);
        check("t6.count", COUNT, 0);
        check("t6.in_ready", IN_READY, 0);
        check("t6.out_pc", OUT_PC, 0);
        tick();
        RST = 1'b0;
        tick();
        check("t6.ready_after", IN_READY, 1);
        IN_VALID = 1'b1; OUT_READY = 1'b1; IN_PC = 32'h6000;
        tick();
        check("t6.first_out", OUT_PC, 32'h6000);
        IN_PC = 32'h6004;
        tick();
        check("t6.second_out", OUT_PC, 32'h6004);
        IN_VALID = 1'b0;
        tick();
        check("t6.empty", OUT_VALID, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
